// File: rtl/axi_clint_if.sv
// Bus bundle for the CLINT slave port: single-beat AXI4 AW/W/B/AR/R channels.
// Ports (slave view):
//   aw_* / w_* / ar_*   requests from the master (valid in, ready out)
//   b_* / r_*           responses to the master (valid out, ready in)
// The master modport is the mirror image and is used by whoever drives the bus.
interface axi_clint_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] aw_id;
    logic [31:0]     aw_addr;
    logic            aw_valid;
    logic            aw_ready;

    logic [63:0]     w_data;
    logic [7:0]      w_strb;
    logic            w_last;
    logic            w_valid;
    logic            w_ready;

    logic [ID_W-1:0] b_id;
    logic [1:0]      b_resp;
    logic            b_valid;
    logic            b_ready;

    logic [ID_W-1:0] ar_id;
    logic [31:0]     ar_addr;
    logic            ar_valid;
    logic            ar_ready;

    logic [ID_W-1:0] r_id;
    logic [63:0]     r_data;
    logic [1:0]      r_resp;
    logic            r_last;
    logic            r_valid;
    logic            r_ready;

    modport slave (
        input  aw_id, aw_addr, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );

    modport master (
        output aw_id, aw_addr, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi_clint.sv
// Core-local timer (CLINT) as an AXI4 slave.
// Holds a free-running, prescaled 64-bit mtime and a 64-bit mtimecmp, serves
// single-beat 64-bit reads/writes to them, and raises timer_intr (registered)
// while mtime >= mtimecmp.
// Ports:
//   clk          clock
//   rst          asynchronous reset, active low
//   axi          slave side of the AXI bundle (axi_clint_if.slave)
//   timer_intr   timer interrupt to the core
module axi_clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TICK_DIV  = 1,
    parameter int          ID_W      = 4
) (
    input  logic            clk,
    input  logic            rst,
    axi_clint_if.slave      axi,
    output logic            timer_intr
);

    localparam logic [31:0] CMP_ADDR  = BASE_ADDR + 32'h0000_4000;
    localparam logic [31:0] TIME_ADDR = BASE_ADDR + 32'h0000_BFF8;
    localparam int          PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old,
                                                input logic [63:0] data,
                                                input logic [7:0]  strb);
        logic [63:0] res;
        res = old;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

    logic [63:0]     mtime;
    logic [63:0]     mtimecmp;
    logic [PW-1:0]   prescale;

    w_state_t        w_state;
    logic            aw_got;
    logic            w_got;
    logic [31:0]     aw_addr_q;
    logic [ID_W-1:0] aw_id_q;
    logic [63:0]     w_data_q;
    logic [7:0]      w_strb_q;

    r_state_t        r_state;

    // Byte-lane offset and w_last carry no information for single-beat
    // 64-bit accesses.
    logic unused_bits;
    assign unused_bits = ^{axi.w_last, axi.aw_addr[2:0], axi.ar_addr[2:0]};

    // A channel's fields come straight from the bus in the cycle it
    // handshakes, otherwise from the latched copy, so the register update
    // can happen in the same cycle the second channel arrives.
    logic            aw_hs, w_hs, aw_have, w_have, wr_fire;
    logic [31:0]     wr_addr;
    logic [ID_W-1:0] wr_id;
    logic [63:0]     wr_data;
    logic [7:0]      wr_strb;
    logic [31:0]     wr_word;
    logic            wr_hit, wr_cmp, wr_time;

    assign aw_hs   = axi.aw_valid && axi.aw_ready;
    assign w_hs    = axi.w_valid && axi.w_ready;
    assign aw_have = aw_got || aw_hs;
    assign w_have  = w_got || w_hs;
    assign wr_fire = (w_state == W_IDLE) && aw_have && w_have;
    assign wr_addr = aw_hs ? axi.aw_addr : aw_addr_q;
    assign wr_id   = aw_hs ? axi.aw_id   : aw_id_q;
    assign wr_data = w_hs  ? axi.w_data  : w_data_q;
    assign wr_strb = w_hs  ? axi.w_strb  : w_strb_q;
    assign wr_word = {wr_addr[31:3], 3'b000};
    assign wr_hit  = (wr_word == CMP_ADDR) || (wr_word == TIME_ADDR);
    assign wr_cmp  = wr_fire && (wr_word == CMP_ADDR);
    assign wr_time = wr_fire && (wr_word == TIME_ADDR);

    logic [31:0] rd_word;
    logic        rd_hit;
    logic [63:0] rd_data;

    assign rd_word = {axi.ar_addr[31:3], 3'b000};
    assign rd_hit  = (rd_word == CMP_ADDR) || (rd_word == TIME_ADDR);
    assign rd_data = (rd_word == CMP_ADDR)  ? mtimecmp :
                     (rd_word == TIME_ADDR) ? mtime    : 64'd0;

    // Timer state: a software write to mtime takes priority over the tick
    // and restarts the prescaler so the next increment is a full period away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime      <= 64'd0;
            mtimecmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
            prescale   <= '0;
            timer_intr <= 1'b0;
        end else begin
            timer_intr <= (mtime >= mtimecmp);
            if (wr_time) begin
                mtime    <= merge_bytes(mtime, wr_data, wr_strb);
                prescale <= '0;
            end else if (prescale == PRE_LAST) begin
                mtime    <= mtime + 64'd1;
                prescale <= '0;
            end else begin
                prescale <= prescale + 1'b1;
            end
            if (wr_cmp) mtimecmp <= merge_bytes(mtimecmp, wr_data, wr_strb);
        end
    end

    // Write FSM: AW and W are captured independently; each ready drops once
    // its channel is held and both stay low until the response is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state      <= W_IDLE;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            aw_addr_q    <= '0;
            aw_id_q      <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            axi.aw_ready <= 1'b0;
            axi.w_ready  <= 1'b0;
            axi.b_valid  <= 1'b0;
            axi.b_id     <= '0;
            axi.b_resp   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_fire) begin
                        w_state      <= W_RESP;
                        aw_got       <= 1'b0;
                        w_got        <= 1'b0;
                        axi.aw_ready <= 1'b0;
                        axi.w_ready  <= 1'b0;
                        axi.b_valid  <= 1'b1;
                        axi.b_id     <= wr_id;
                        axi.b_resp   <= wr_hit ? RESP_OKAY : RESP_DECERR;
                    end else begin
                        if (aw_hs) begin
                            aw_got    <= 1'b1;
                            aw_addr_q <= axi.aw_addr;
                            aw_id_q   <= axi.aw_id;
                        end
                        if (w_hs) begin
                            w_got    <= 1'b1;
                            w_data_q <= axi.w_data;
                            w_strb_q <= axi.w_strb;
                        end
                        axi.aw_ready <= !aw_have;
                        axi.w_ready  <= !w_have;
                    end
                end
                W_RESP: begin
                    if (axi.b_ready) begin
                        w_state      <= W_IDLE;
                        axi.b_valid  <= 1'b0;
                        axi.aw_ready <= 1'b1;
                        axi.w_ready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: data is sampled at the AR handshake, before any same-cycle
    // write lands, and held on R until the master takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= R_IDLE;
            axi.ar_ready <= 1'b0;
            axi.r_valid  <= 1'b0;
            axi.r_last   <= 1'b0;
            axi.r_id     <= '0;
            axi.r_data   <= '0;
            axi.r_resp   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi.ar_valid && axi.ar_ready) begin
                        r_state      <= R_RESP;
                        axi.ar_ready <= 1'b0;
                        axi.r_valid  <= 1'b1;
                        axi.r_last   <= 1'b1;
                        axi.r_id     <= axi.ar_id;
                        axi.r_data   <= rd_data;
                        axi.r_resp   <= rd_hit ? RESP_OKAY : RESP_DECERR;
                    end else begin
                        axi.ar_ready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (axi.r_ready) begin
                        r_state      <= R_IDLE;
                        axi.r_valid  <= 1'b0;
                        axi.r_last   <= 1'b0;
                        axi.ar_ready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_clint.sv
// Directed self-checking bench for axi_clint.
// Two instances share one set of master-side drivers: dut1 (TICK_DIV=1) and
// dut4 (TICK_DIV=4); 'sel' picks which one sees valid/ready and is observed.
module tb_axi_clint;

    localparam logic [31:0] BASE  = 32'h0200_0000;
    localparam logic [31:0] CMP   = BASE + 32'h4000;
    localparam logic [31:0] MTIME = BASE + 32'hBFF8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  aw_id = '0;
    logic [31:0] aw_addr = '0;
    logic        aw_valid = 1'b0;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        w_last = 1'b0;
    logic        w_valid = 1'b0;
    logic        b_ready = 1'b0;
    logic [3:0]  ar_id = '0;
    logic [31:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        r_ready = 1'b0;

    logic intr1, intr4;

    axi_clint_if #(.ID_W(4)) bus1 ();
    axi_clint_if #(.ID_W(4)) bus4 ();

    assign bus1.aw_id = aw_id;     assign bus4.aw_id = aw_id;
    assign bus1.aw_addr = aw_addr; assign bus4.aw_addr = aw_addr;
    assign bus1.w_data = w_data;   assign bus4.w_data = w_data;
    assign bus1.w_strb = w_strb;   assign bus4.w_strb = w_strb;
    assign bus1.w_last = w_last;   assign bus4.w_last = w_last;
    assign bus1.ar_id = ar_id;     assign bus4.ar_id = ar_id;
    assign bus1.ar_addr = ar_addr; assign bus4.ar_addr = ar_addr;
    assign bus1.aw_valid = aw_valid & ~sel; assign bus4.aw_valid = aw_valid & sel;
    assign bus1.w_valid  = w_valid & ~sel;  assign bus4.w_valid  = w_valid & sel;
    assign bus1.b_ready  = b_ready & ~sel;  assign bus4.b_ready  = b_ready & sel;
    assign bus1.ar_valid = ar_valid & ~sel; assign bus4.ar_valid = ar_valid & sel;
    assign bus1.r_ready  = r_ready & ~sel;  assign bus4.r_ready  = r_ready & sel;

    logic        m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid, m_r_last;
    logic [3:0]  m_b_id, m_r_id;
    logic [1:0]  m_b_resp, m_r_resp;
    logic [63:0] m_r_data;

    assign m_aw_ready = sel ? bus4.aw_ready : bus1.aw_ready;
    assign m_w_ready  = sel ? bus4.w_ready  : bus1.w_ready;
    assign m_b_valid  = sel ? bus4.b_valid  : bus1.b_valid;
    assign m_b_id     = sel ? bus4.b_id     : bus1.b_id;
    assign m_b_resp   = sel ? bus4.b_resp   : bus1.b_resp;
    assign m_ar_ready = sel ? bus4.ar_ready : bus1.ar_ready;
    assign m_r_valid  = sel ? bus4.r_valid  : bus1.r_valid;
    assign m_r_id     = sel ? bus4.r_id     : bus1.r_id;
    assign m_r_data   = sel ? bus4.r_data   : bus1.r_data;
    assign m_r_resp   = sel ? bus4.r_resp   : bus1.r_resp;
    assign m_r_last   = sel ? bus4.r_last   : bus1.r_last;

    axi_clint #(.BASE_ADDR(BASE), .TICK_DIV(1), .ID_W(4)) dut1 (
        .clk(clk), .rst(rst), .axi(bus1.slave), .timer_intr(intr1)
    );

    axi_clint #(.BASE_ADDR(BASE), .TICK_DIV(4), .ID_W(4)) dut4 (
        .clk(clk), .rst(rst), .axi(bus4.slave), .timer_intr(intr4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives AW and W (W leading AW by w_lead cycles); returns at the falling
    // edge after the edge on which the last of the two handshakes happened,
    // with fire_cyc = index of that edge.
    task automatic send_write(input logic [31:0] addr, input logic [63:0] data,
                              input logic [7:0] strb, input logic [3:0] id,
                              input int w_lead, output int fire_cyc);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs, w_hs;
        int n = 0;
        @(negedge clk);
        aw_addr = addr; aw_id = id; w_data = data; w_strb = strb; w_last = 1'b1;
        w_valid = 1'b1;
        aw_valid = (w_lead == 0);
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = aw_valid && m_aw_ready;
            w_hs  = w_valid && m_w_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
            if (aw_hs) begin aw_done = 1; aw_valid = 1'b0; end
            if (w_hs)  begin w_done = 1;  w_valid = 1'b0; end
            if (!aw_done && n >= w_lead) aw_valid = 1'b1;
        end
        aw_valid = 1'b0;
        w_valid = 1'b0;
        check("aw_w_handshake", 64'(aw_done && w_done), 64'd1);
        fire_cyc = cyc;
    endtask

    // Called at a falling edge; waits for B and accepts it.
    task automatic take_b(output logic [1:0] resp, output logic [3:0] id);
        int n = 0;
        while (!m_b_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_valid_seen", 64'(m_b_valid), 64'd1);
        resp = m_b_resp;
        id = m_b_id;
        b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input logic [3:0] id,
                             output logic [1:0] resp, output logic [3:0] bid);
        int fc;
        send_write(addr, data, strb, id, 0, fc);
        take_b(resp, bid);
    endtask

    // hs_cyc = index of the edge on which AR handshook (data sampled there).
    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id,
                            output logic [63:0] data, output logic [1:0] resp,
                            output logic last, output logic [3:0] rid,
                            output int hs_cyc);
        bit done = 0;
        bit hs;
        int n = 0;
        @(negedge clk);
        ar_addr = addr; ar_id = id; ar_valid = 1'b1;
        while (!done && n < 50) begin
            hs = m_ar_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
            if (hs) done = 1;
        end
        ar_valid = 1'b0;
        hs_cyc = cyc;
        check("ar_handshake", 64'(done), 64'd1);
        n = 0;
        while (!m_r_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("r_valid_seen", 64'(m_r_valid), 64'd1);
        data = m_r_data; resp = m_r_resp; last = m_r_last; rid = m_r_id;
        r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] rdata;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        int          we, hs;
        logic [63:0] exp_time;

        // Reset: all outputs low while rst is held.
        repeat (3) @(negedge clk);
        check("rst_aw_ready", 64'(m_aw_ready), 64'd0);
        check("rst_w_ready",  64'(m_w_ready),  64'd0);
        check("rst_ar_ready", 64'(m_ar_ready), 64'd0);
        check("rst_b", {59'd0, m_b_valid, m_b_id}, 64'd0);
        check("rst_r", {57'd0, m_r_valid, m_r_last, m_r_resp, m_r_id}, 64'd0);
        check("rst_r_data", m_r_data, 64'd0);
        check("rst_intr", 64'(intr1), 64'd0);
        rst = 1'b1;

        axi_read(CMP, 4'h5, rdata, resp, last, id, hs);
        check("rd_cmp_reset", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rd_cmp_resp", 64'(resp), 64'd0);
        check("rd_cmp_last", 64'(last), 64'd1);
        check("rd_cmp_id", 64'(id), 64'h5);
        check("intr_idle", 64'(intr1), 64'd0);

        // Interrupt rise/fall timing (TICK_DIV=1).
        axi_write(MTIME, 64'd0, 8'hFF, 4'h1, resp, id);
        check("wr_mtime_resp", 64'(resp), 64'd0);
        axi_write(CMP, 64'h20, 8'hFF, 4'h2, resp, id);
        check("wr_cmp_resp", 64'(resp), 64'd0);
        send_write(MTIME, 64'h10, 8'hFF, 4'h3, 0, we);
        take_b(resp, id);
        while (cyc < we + 16) @(negedge clk);
        check("intr_before_rise", 64'(intr1), 64'd0);
        @(negedge clk);
        check("intr_rise", 64'(intr1), 64'd1);
        send_write(CMP, 64'h100, 8'hFF, 4'h4, 0, we);
        check("intr_before_fall", 64'(intr1), 64'd1);
        @(negedge clk);
        check("intr_fall", 64'(intr1), 64'd0);
        take_b(resp, id);

        // W three cycles ahead of AW, partial strobes, stalled B.
        axi_write(CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'h6, resp, id);
        send_write(CMP, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 4'h9, 3, we);
        for (int i = 0; i < 5; i++) begin
            check("b_stall", {58'd0, m_b_valid, m_b_id, m_aw_ready}, {58'd0, 1'b1, 4'h9, 1'b0});
            @(negedge clk);
        end
        take_b(resp, id);
        check("strb_b_id", 64'(id), 64'h9);
        check("strb_b_resp", 64'(resp), 64'd0);
        axi_read(CMP, 4'h2, rdata, resp, last, id, hs);
        check("strb_readback", rdata, 64'hFFFF_FFFF_CCCC_DDDD);
        axi_write(CMP, 64'h0000_0001_0000_0000, 8'hFF, 4'hC, resp, id);
        check("next_wr_resp", 64'(resp), 64'd0);
        check("next_wr_id", 64'(id), 64'hC);

        // Unmapped address.
        axi_read(BASE + 32'h10, 4'h7, rdata, resp, last, id, hs);
        check("decerr_rd_resp", 64'(resp), 64'h3);
        check("decerr_rd_data", rdata, 64'd0);
        check("decerr_rd_last", 64'(last), 64'd1);
        axi_write(BASE + 32'h10, 64'h1234, 8'hFF, 4'hA, resp, id);
        check("decerr_wr_resp", 64'(resp), 64'h3);
        check("decerr_wr_id", 64'(id), 64'hA);
        axi_read(CMP, 4'h1, rdata, resp, last, id, hs);
        check("decerr_cmp_kept", rdata, 64'h0000_0001_0000_0000);

        // TICK_DIV=4 wrap of mtime.
        @(negedge clk);
        sel = 1'b1;
        send_write(MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 4'h3, 0, we);
        take_b(resp, id);
        check("div4_wr_resp", 64'(resp), 64'd0);
        axi_read(MTIME, 4'h1, rdata, resp, last, id, hs);
        exp_time = 64'hFFFF_FFFF_FFFF_FFFE + 64'((hs - 1 - we) / 4);
        check("div4_rd0", rdata, exp_time);
        while (cyc < we + 5) @(negedge clk);
        axi_read(MTIME, 4'h1, rdata, resp, last, id, hs);
        exp_time = 64'hFFFF_FFFF_FFFF_FFFE + 64'((hs - 1 - we) / 4);
        check("div4_rd1", rdata, exp_time);
        while (cyc < we + 10) @(negedge clk);
        axi_read(MTIME, 4'h1, rdata, resp, last, id, hs);
        exp_time = 64'hFFFF_FFFF_FFFF_FFFE + 64'((hs - 1 - we) / 4);
        check("div4_wrap", rdata, exp_time);
        check("div4_intr", 64'(intr4), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_clint.md
Name:
axi_clint

Overview:
AXI4 slave timer (CLINT) on the SoC's external AXI master port, decoded below the arbiter; returns `timer_intr` to the core, replacing the tied-off constant. Holds 64-bit `mtime` (free-running, prescaled) and `mtimecmp`, serves single-beat 64-bit reads/writes, and asserts `timer_intr` while `mtime >= mtimecmp`.

Parameters:
`BASE_ADDR`, 32'h0200_0000, CLINT base; `mtimecmp` at `BASE+0x4000`, `mtime` at `BASE+0xBFF8`
`TICK_DIV`, 1, clk cycles per `mtime` increment (>=1)
`ID_W`, 4, AXI ID width

Ports:
`clk`  in  1  clock
`rst`  in  1  asynchronous reset, active-low
`axi_aw_id`  in  ID_W  write ID
`axi_aw_addr`  in  32  write address
`axi_aw_valid`  in  1  AW valid
`axi_aw_ready`  out  1  AW ready
`axi_w_data`  in  64  write data
`axi_w_strb`  in  8  byte strobes
`axi_w_last`  in  1  must be 1 (single beat)
`axi_w_valid`  in  1  W valid
`axi_w_ready`  out  1  W ready
`axi_b_id`  out  ID_W  echoed AW ID
`axi_b_resp`  out  2  OKAY/DECERR
`axi_b_valid`  out  1  B valid
`axi_b_ready`  in  1  B ready
`axi_ar_id`  in  ID_W  read ID
`axi_ar_addr`  in  32  read address
`axi_ar_valid`  in  1  AR valid
`axi_ar_ready`  out  1  AR ready
`axi_r_id`  out  ID_W  echoed AR ID
`axi_r_data`  out  64  read data
`axi_r_resp`  out  2  OKAY/DECERR
`axi_r_last`  out  1  always 1 with `axi_r_valid`
`axi_r_valid`  out  1  R valid
`axi_r_ready`  in  1  R ready
`timer_intr`  out  1  timer interrupt to core

Behaviour:
- Reset (`rst`=0, async): `mtime`=0, prescaler=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, all valids/readys/`timer_intr`=0, `b_*`/`r_*` outputs 0.
- Prescaler counts 0..`TICK_DIV-1`; `mtime` += 1 on wrap, wrapping at 2^64 to 0. A write to `mtime` in the same cycle wins over the increment and clears the prescaler.
- `timer_intr` is registered: cycle N compare (`mtime >= mtimecmp`, unsigned) drives the output in N+1; it deasserts the same way once `mtimecmp` is raised.
- **Write FSM `W_IDLE → W_RESP`:**
  - `aw_ready`/`w_ready` = 1 in `W_IDLE` for each channel not yet captured; AW and W are latched independently in any order or cycle.
  - Once both are latched: register update occurs that cycle (byte-wise per `strb`, address bits [2:0] ignored), then `b_valid`=1 next cycle, state `W_RESP`.
  - `b_valid`, `b_id` and `b_resp` are held until `b_ready`, then return to `W_IDLE`.
- **Read FSM `R_IDLE → R_RESP`:**
  - `ar_ready`=1 in `R_IDLE`; on handshake in cycle N, data is sampled in N and `r_valid`=1 in N+1.
  - `r_id`, `r_data`, `r_resp` and `r_last` are held until `r_ready`, then return to `R_IDLE`.
- Decode compares the full address with [2:0] masked; any other address → DECERR (2'b11), write dropped, read data 0.
- Read and write channels are independent. A read sampled in the same cycle as a write to the same register returns the pre-write value.

Test Plan:
- Reset, hold `rst`=0 then release → all outputs 0; read `BASE+0x4000` → `r_data`=64'hFFFF…FFFF, `r_resp`=0.
- `TICK_DIV`=1: write `mtimecmp`=0x20 → `timer_intr` rises exactly 1 cycle after `mtime` reaches 0x20; write `mtimecmp`=0x100 → `timer_intr` drops 1 cycle later.
- W issued 3 cycles before AW, `strb`=8'h0F, `data`=64'hAAAA_BBBB_CCCC_DDDD to `mtimecmp` (previously all-ones) → readback 64'hFFFF_FFFF_CCCC_DDDD; `b_id` equals `aw_id`.
- `b_ready` held low 5 cycles → `b_valid`/`b_id` stable, `aw_ready`=0 throughout; handshake → next write accepted.
- Read `BASE+0x10` → `r_resp`=2'b11, `r_data`=0, `r_last`=1; write there → `b_resp`=2'b11, no register changes.
- `TICK_DIV`=4: write `mtime`=64'hFFFF_FFFF_FFFF_FFFE → reads show wrap to 0 after 8 cycles.
